// File: rtl/risc16_trace_buffer_if.sv
// ============================================================================
//  Module      : risc16_trace_buffer_if
//  Description : Capture, trigger and read-port bundle of the RiSC-16
//                instruction trace buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface risc16_trace_buffer_if #(
  parameter int WORD_W     = 16,
  parameter int DEPTH      = 16,
  parameter int REG_ADDR_W = 3
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                  cap_valid;
  logic [WORD_W-1:0]     cap_pc;
  logic [WORD_W-1:0]     cap_instr;
  logic                  cap_wb_en;
  logic [REG_ADDR_W-1:0] cap_wb_reg;
  logic [WORD_W-1:0]     cap_wb_data;

  logic                  arm;
  logic                  mode;
  logic                  trig_en;
  logic [WORD_W-1:0]     trig_pc;

  logic                  rd_valid;
  logic                  rd_ready;
  logic [WORD_W-1:0]     rd_pc;
  logic [WORD_W-1:0]     rd_instr;
  logic                  rd_wb_en;
  logic [REG_ADDR_W-1:0] rd_wb_reg;
  logic [WORD_W-1:0]     rd_wb_data;

  logic [1:0]            state;
  logic [CNT_W-1:0]      count;
  logic                  overflow;

  modport master (
    output cap_valid, cap_pc, cap_instr, cap_wb_en, cap_wb_reg, cap_wb_data,
    output arm, mode, trig_en, trig_pc, rd_ready,
    input  rd_valid, rd_pc, rd_instr, rd_wb_en, rd_wb_reg, rd_wb_data,
    input  state, count, overflow
  );

  modport slave (
    input  cap_valid, cap_pc, cap_instr, cap_wb_en, cap_wb_reg, cap_wb_data,
    input  arm, mode, trig_en, trig_pc, rd_ready,
    output rd_valid, rd_pc, rd_instr, rd_wb_en, rd_wb_reg, rd_wb_data,
    output state, count, overflow
  );
endinterface

`default_nettype wire

// File: rtl/risc16_trace_buffer.sv
// ============================================================================
//  Module      : risc16_trace_buffer
//  Description : Circular retired-instruction trace store with fill-and-stop
//                and PC-triggered ring capture, drained via valid/ready.
//                Define RISC16_TRACE_FILTER_EN to record only writeback captures.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module risc16_trace_buffer #(
  parameter int WORD_W     = 16,
  parameter int DEPTH      = 16,
  parameter int REG_ADDR_W = 3,
  parameter int POST_TRIG  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  risc16_trace_buffer_if.slave  bus
);

  localparam int             AW      = $clog2(DEPTH);
  localparam logic [AW:0]    FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0]    LAST    = (AW+1)'(DEPTH - 1);
  localparam logic [AW-1:0]  POST_LD = AW'(POST_TRIG);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_POST    = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  typedef struct packed {
    logic [WORD_W-1:0]     pc;
    logic [WORD_W-1:0]     instr;
    logic                  wb_en;
    logic [REG_ADDR_W-1:0] wb_reg;
    logic [WORD_W-1:0]     wb_data;
  } entry_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          mode_q, mode_d;
  logic [AW-1:0] post_q, post_d;

  entry_t        mem [DEPTH];
  entry_t        wr_entry;
  entry_t        rd_entry;
  logic          wr_en;
  logic          rec;
  logic          trig_hit;
  logic          rd_valid;
  logic          pop;

  // arm takes priority, so a capture on the arming cycle is never recorded
`ifdef RISC16_TRACE_FILTER_EN
  assign rec = bus.cap_valid && bus.cap_wb_en && !bus.arm;
`else
  assign rec = bus.cap_valid && !bus.arm;
`endif

  assign trig_hit = bus.trig_en && (bus.cap_pc == bus.trig_pc);
  assign rd_valid = (state_q == ST_DONE) && (count_q != '0);
  assign pop      = rd_valid && bus.rd_ready;

  assign wr_entry = '{pc:      bus.cap_pc,
                      instr:   bus.cap_instr,
                      wb_en:   bus.cap_wb_en,
                      wb_reg:  bus.cap_wb_reg,
                      wb_data: bus.cap_wb_data};

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    mode_d     = mode_q;
    post_d     = post_q;
    wr_en      = 1'b0;

    if (bus.arm) begin
      state_d    = ST_CAPTURE;
      mode_d     = bus.mode;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_CAPTURE, ST_POST: begin
          if (rec) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            // Full ring: overwrite the oldest entry and drop it from the read side
            if (count_q == FULL) begin
              rd_ptr_d   = rd_ptr_q + 1'b1;
              overflow_d = 1'b1;
            end else begin
              count_d = count_q + 1'b1;
            end

            if (!mode_q) begin
              if (count_q == LAST) state_d = ST_DONE;
            end else if (state_q == ST_CAPTURE) begin
              if (trig_hit) begin
                if (POST_TRIG == 0) begin
                  state_d = ST_DONE;
                end else begin
                  state_d = ST_POST;
                  post_d  = POST_LD;
                end
              end
            end else begin
              post_d = post_q - 1'b1;
              if (post_q == AW'(1)) state_d = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            count_d  = count_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      mode_q     <= 1'b0;
      post_q     <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      mode_q     <= mode_d;
      post_q     <= post_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= wr_entry;
  end

  assign rd_entry = rd_valid ? mem[rd_ptr_q] : '0;

  assign bus.rd_valid   = rd_valid;
  assign bus.rd_pc      = rd_entry.pc;
  assign bus.rd_instr   = rd_entry.instr;
  assign bus.rd_wb_en   = rd_entry.wb_en;
  assign bus.rd_wb_reg  = rd_entry.wb_reg;
  assign bus.rd_wb_data = rd_entry.wb_data;
  assign bus.state      = state_q;
  assign bus.count      = count_q;
  assign bus.overflow   = overflow_q;

endmodule

`default_nettype wire

// File: doc/risc16_trace_buffer.md
# risc16_trace_buffer

Parametrised on-chip instruction trace buffer for the RiSC-16 core. It records retired-instruction records (PC, instruction word, register-file writeback) into a circular store, stops on a fill or PC-match trigger, and drains the capture through a valid/ready read port. It sits beside `risc16_processor` and replaces waveform-only visibility with a synthesizable, bench- and FPGA-readable trace.

## Interface
- `WORD_W`, default 16: PC, instruction and data width.
- `DEPTH`, default 16: number of entries; must be a power of 2 and ≥ 4.
- `REG_ADDR_W`, default 3: register index width.
- `POST_TRIG`, default 8: entries captured after the trigger entry in ring mode; range 0..DEPTH-1.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous reset, active-high.
- `cap_valid` in 1: one instruction retires this cycle.
- `cap_pc` in WORD_W: PC of the retiring instruction.
- `cap_instr` in WORD_W: its instruction word.
- `cap_wb_en` in 1: register-file write enable.
- `cap_wb_reg` in REG_ADDR_W: destination register.
- `cap_wb_data` in WORD_W: write data.
- `arm` in 1: single-cycle start/restart pulse.
- `mode` in 1: 0 = fill-and-stop, 1 = ring with trigger; sampled only on `arm`.
- `trig_en` in 1: enables PC-match trigger.
- `trig_pc` in WORD_W: trigger PC.
- `rd_valid` out 1: oldest entry is presented.
- `rd_ready` in 1: consumer accepts the entry.
- `rd_pc`, `rd_instr`, `rd_wb_data` out WORD_W; `rd_wb_en` out 1; `rd_wb_reg` out REG_ADDR_W: entry fields.
- `state` out 2: 0 IDLE, 1 CAPTURE, 2 POST, 3 DONE.
- `count` out clog2(DEPTH)+1: valid entries held.
- `overflow` out 1: at least one entry was overwritten since the last `arm`.

## Operation
- **IDLE:** no capture. `arm` goes to CAPTURE, latches `mode`, and clears write pointer, read pointer, `count` and `overflow`.
- **CAPTURE, mode 0:**
  - Each recorded `cap_valid` writes one entry and increments `count`.
  - The write that makes `count` equal DEPTH moves to DONE.
  - The trigger is ignored.
- **CAPTURE, mode 1:**
  - Ring buffer. Once full, each write overwrites the oldest entry, advances the read pointer, holds `count` at DEPTH, and sets `overflow`.
  - A recorded capture with `trig_en`=1 and `cap_pc`==`trig_pc` writes the trigger entry.
  - It then moves to POST with the post counter loaded to POST_TRIG, or to DONE if POST_TRIG=0.
- **POST:** each recorded capture writes, with ring semantics, and decrements the post counter. The write that reaches 0 moves to DONE. Further trigger matches are ignored.
- **DONE:**
  - Capture is frozen and `rd_valid` = (`count` > 0).
  - A handshake (`rd_valid` && `rd_ready`) pops the oldest entry: the read pointer wraps mod DEPTH and `count` decrements.
  - Draining to 0 stays in DONE.
- **Read port outside DONE:** `rd_valid`=0, and `rd_*` data is driven to 0 whenever `rd_valid`=0.
- **`arm` in any state:** restarts as described for IDLE, discarding held entries.
- **`arm` and `cap_valid` in the same cycle:** `arm` wins and the capture is not recorded.
- **Reset:** `rst` overrides everything. `state`=IDLE, `count`=0, `overflow`=0, `rd_valid`=0, all `rd_*`=0. Storage contents are don't-care.

## Timing
- Capture writes on the rising edge where it is recorded. `count`, `state` and `overflow` update on that same edge and are visible the following cycle.
- Read data comes combinationally from the read pointer, so the entry is visible in the same cycle that `rd_valid` rises.
- `rd_*` holds stable while `rd_valid` && !`rd_ready`.
- Throughput is one pop per cycle.
- Entering DONE on edge N gives `rd_valid`=1 in cycle N+1.

## Configuration
- **`RISC16_TRACE_FILTER_EN` defined:** a capture is recorded only when `cap_valid` && `cap_wb_en`. Trigger matching and post-counting still use the recorded-capture condition, so a matching PC without writeback does not trigger.
- **`RISC16_TRACE_FILTER_EN` undefined:** every `cap_valid` is recorded.

## Test plan
- **Idle after reset:** `rst`, then 5 `cap_valid` pulses with no `arm` → `state`=0, `count`=0, `rd_valid`=0, `rd_pc`=0.
- **Fill-and-stop:** mode 0, DEPTH=16, 20 consecutive captures with PC 0x0000..0x0013 → DONE after the 16th, `count`=16, `overflow`=0. Drain with `rd_ready`=1 returns PC 0x0000..0x000F in order, then `rd_valid`=0.
- **Ring with trigger:** mode 1, POST_TRIG=4, `trig_pc`=0x0020, captures with PC 0x0000 upward → DONE after PC 0x0024. Buffer holds PC 0x0015..0x0024, `overflow`=1, `count`=16.
- **Backpressure:** in DONE, toggle `rd_ready` 1-0-0-1 → each entry is popped exactly once and `rd_*` is unchanged while stalled.
- **Collisions and reset:**
  - `arm` and `cap_valid` in the same cycle → first entry comes from the next capture.
  - `rst` asserted mid-POST → IDLE, `count`=0, `overflow`=0 on the next cycle.
- **Filter:** with `RISC16_TRACE_FILTER_EN`, mode 0, 8 captures alternating `cap_wb_en`=1/0 → `count`=4, holding only the entries with `wb_en`=1.
